ripple_carry_adder: RTL and testbench



---
 rtl/ripple_carry_adder.sv | 51 +++++
 tb/tb_ripple_carry_adder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder.sv
// Registered N-bit ripple-carry adder with carry-out and signed overflow.
// One operand set per clock, one-cycle latency, valid travels with data.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf_next;

    // Carry chain: each cell consumes the carry of the cell below it.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    assign ovf_next = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= s;
                Cout <= c[WIDTH];
                ovf  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at WIDTH=4.
// Expected results are queued at drive time and popped after the edge.
module tb_ripple_carry_adder;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         ovf;
    logic         out_valid;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sum       (Sum),
        .Cout      (Cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Independent reference: behavioural add plus signed-range test.
    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic cin);
        exp_t       e;
        logic [W:0] t;
        int         sa;
        int         sb;
        int         ss;
        t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        ss = sa + sb + int'(cin);
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
        return e;
    endfunction

    task automatic drive(input logic r, input logic v,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = cin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if ({Sum, Cout, ovf, out_valid} !== 7'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got sum=%b cout=%b ovf=%b vld=%b, required all 0",
                         k, Sum, Cout, ovf, out_valid);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[6]  = '{4'b0001, 4'b1010, 4'b1101, 4'b1111, 4'b1111, 4'b0001};
        logic [W-1:0] vb[6]  = '{4'b0000, 4'b0011, 4'b1010, 4'b1111, 4'b1111, 4'b1011};
        logic         vc[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] xs[6]  = '{4'b0001, 4'b1101, 4'b1000, 4'b1111, 4'b1110, 4'b1100};
        logic         xc[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_t         e;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, va[k], vb[k], vc[k]);
            e      = model(va[k], vb[k], vc[k]);
            e.sum  = xs[k];
            e.cout = xc[k];
            q.push_back(e);
            tick();
            e = q.pop_front();
            n_cmp++;
            if ({Sum, Cout, ovf, out_valid} !== {e.sum, e.cout, e.ovf, 1'b1}) begin
                n_bad++;
                $display("FAIL directed[%0d]: got sum=%b cout=%b ovf=%b vld=%b, required sum=%b cout=%b ovf=%b vld=1",
                         k, Sum, Cout, ovf, out_valid, e.sum, e.cout, e.ovf);
            end
        end
    endtask

    task automatic test_ripple();
        exp_t e;
        drive(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
        q.push_back('{sum: 4'b0000, cout: 1'b1, ovf: 1'b0});
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({Sum, Cout, ovf, out_valid} !== {e.sum, e.cout, e.ovf, 1'b1}) begin
            n_bad++;
            $display("FAIL ripple_full: got sum=%b cout=%b ovf=%b vld=%b, required sum=%b cout=%b ovf=%b vld=1",
                     Sum, Cout, ovf, out_valid, e.sum, e.cout, e.ovf);
        end
        drive(1'b0, 1'b1, 4'b0111, 4'b0000, 1'b1);
        q.push_back('{sum: 4'b1000, cout: 1'b0, ovf: 1'b1});
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({Sum, Cout, ovf, out_valid} !== {e.sum, e.cout, e.ovf, 1'b1}) begin
            n_bad++;
            $display("FAIL ripple_ovf: got sum=%b cout=%b ovf=%b vld=%b, required sum=%b cout=%b ovf=%b vld=1",
                     Sum, Cout, ovf, out_valid, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(1'b0, 1'b1, 4'b0110, 4'b0111, 1'b0);
        q.push_back(model(4'b0110, 4'b0111, 1'b0));
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({Sum, Cout, ovf, out_valid} !== {e.sum, e.cout, e.ovf, 1'b1}) begin
            n_bad++;
            $display("FAIL hold_load: got sum=%b cout=%b ovf=%b vld=%b, required sum=%b cout=%b ovf=%b vld=1",
                     Sum, Cout, ovf, out_valid, e.sum, e.cout, e.ovf);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 4'(k * 5 + 3), 4'(k * 3 + 9), k[0]);
            tick();
            n_cmp++;
            if ({Sum, Cout, ovf, out_valid} !== {e.sum, e.cout, e.ovf, 1'b0}) begin
                n_bad++;
                $display("FAIL hold[%0d]: got sum=%b cout=%b ovf=%b vld=%b, required sum=%b cout=%b ovf=%b vld=0",
                         k, Sum, Cout, ovf, out_valid, e.sum, e.cout, e.ovf);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        drive(1'b1, 1'b1, 4'b0101, 4'b0101, 1'b0);
        tick();
        n_cmp++;
        if ({Sum, Cout, ovf, out_valid} !== 7'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got sum=%b cout=%b ovf=%b vld=%b, required all 0",
                     Sum, Cout, ovf, out_valid);
        end
        drive(1'b0, 1'b0, 4'b0101, 4'b0101, 1'b0);
        tick();
        n_cmp++;
        if ({Sum, Cout, ovf, out_valid} !== 7'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got sum=%b cout=%b ovf=%b vld=%b, required all 0",
                     Sum, Cout, ovf, out_valid);
        end
        drive(1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0);
        q.push_back('{sum: 4'b0111, cout: 1'b0, ovf: 1'b0});
        tick();
        e = q.pop_front();
        n_cmp++;
        if ({Sum, Cout, ovf, out_valid} !== {e.sum, e.cout, e.ovf, 1'b1}) begin
            n_bad++;
            $display("FAIL post_reset_vec: got sum=%b cout=%b ovf=%b vld=%b, required sum=%b cout=%b ovf=%b vld=1",
                     Sum, Cout, ovf, out_valid, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    drive(1'b0, 1'b1, a[W-1:0], b[W-1:0], ci[0]);
                    q.push_back(model(a[W-1:0], b[W-1:0], ci[0]));
                    tick();
                    e = q.pop_front();
                    n_cmp++;
                    if ({Sum, Cout, ovf, out_valid} !== {e.sum, e.cout, e.ovf, 1'b1}) begin
                        n_bad++;
                        $display("FAIL sweep a=%0d b=%0d cin=%0d: got sum=%b cout=%b ovf=%b vld=%b, required sum=%b cout=%b ovf=%b vld=1",
                                 a, b, ci, Sum, Cout, ovf, out_valid, e.sum, e.cout, e.ovf);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got vld=%b queue=%0d, required vld=0 queue=0",
                     out_valid, q.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        test_reset();
        test_directed();
        test_ripple();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
